iob_wb_arbiter: RTL

//  Shares one Wishbone master port between N_REQ IOb requesters, e.g. CPU and DMA into the ethmac register/BD space.

---
 rtl/iob_wb_arbiter_pkg.sv | 4 +
 rtl/iob_wb_arbiter_rr.sv | 24 ++
 rtl/iob_wb_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/iob_wb_arbiter_pkg.sv
// iob_wb_arbiter_pkg: shared FSM state encoding for the IOb-to-Wishbone arbiter.
package iob_wb_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/iob_wb_arbiter_rr.sv
// iob_wb_arbiter_rr: combinational round-robin grant with a registered last-grant pointer.
module iob_wb_arbiter_rr
  import iob_wb_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [N-1:0]  valid,
  input  logic          en,
  output logic [IW-1:0] grant
);
  logic [IW-1:0] ptr;
  // Scan farthest-first so the nearest valid after ptr overwrites the rest.
  always_comb begin
    grant = ptr;
    for (int i = N; i >= 1; i--)
      if (valid[(int'(ptr) + i) % N]) grant = IW'((int'(ptr) + i) % N);
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) ptr <= IW'(N - 1);
    else if (en) ptr <= grant;
endmodule

// File: rtl/iob_wb_arbiter.sv
// iob_wb_arbiter: round-robin share of one Wishbone classic master among N_REQ IOb requesters.
// Define WB_ARB_TIMEOUT_EN to end a BUS cycle in error after a TIMEOUT_W-bit count expires.
module iob_wb_arbiter
  import iob_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  input  logic [N_REQ*DATA_W/8-1:0] req_wstrb_i,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          req_err_o,
  output logic [ADDR_W-1:0]         wb_addr_o,
  output logic [DATA_W-1:0]         wb_data_o,
  output logic [DATA_W/8-1:0]       wb_select_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_error_i,
  input  logic [DATA_W-1:0]         wb_data_i
);
  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(N_REQ);
  state_t state, state_nxt;
  logic [IW-1:0] gnt, gnt_q;
  logic [SW-1:0] strb;
  logic [DATA_W-1:0] rdata_q;
  logic err_q, en, tmo;
  assign en = state == IDLE && |req_valid_i;
  assign strb = req_wstrb_i[int'(gnt)*SW +: SW];
  iob_wb_arbiter_rr #(.N(N_REQ)) u_rr (
    .clk(clk_i), .arst_n(arst_n_i), .valid(req_valid_i), .en(en), .grant(gnt)
  );
`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt, cnt_inc;
  assign cnt_inc = cnt + 1'b1;
  assign tmo = &cnt_inc;
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) cnt <= '0;
    else cnt <= state == BUS ? cnt_inc : '0;
`else
  assign tmo = TIMEOUT_W == 0;
`endif
  always_comb
    state_nxt = state == IDLE ? (|req_valid_i ? BUS : IDLE) :
                state == BUS  ? (wb_error_i || wb_ack_i || tmo ? RESP : BUS) : IDLE;
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) state <= IDLE;
    else state <= state_nxt;
  // Response capture runs every BUS cycle; only the terminating cycle's value survives into RESP.
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      gnt_q <= '0;
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_select_o <= '0;
      wb_we_o <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else if (en) begin
      gnt_q <= gnt;
      wb_addr_o <= req_addr_i[int'(gnt)*ADDR_W +: ADDR_W];
      wb_data_o <= req_wdata_i[int'(gnt)*DATA_W +: DATA_W];
      wb_select_o <= |strb ? strb : '1;
      wb_we_o <= |strb;
    end else if (state == BUS) begin
      rdata_q <= wb_ack_i && !wb_error_i ? wb_data_i : '0;
      err_q <= wb_error_i || !wb_ack_i;
    end
  assign wb_cyc_o = state == BUS;
  assign wb_stb_o = state == BUS;
  assign req_ready_o = state == RESP ? N_REQ'(1) << gnt_q : '0;
  assign req_err_o = err_q ? req_ready_o : '0;
  assign req_rdata_o = state == RESP ? rdata_q : '0;
endmodule
